// File: rtl/in_driver.sv
// in_driver: memory-mapped 8-bit input port; 2-flop sync, per-bit debounce, sticky read-to-clear edge flags, maskable irq.
// Latency: pin to debounced value 2+DEBOUNCE_CYCLES edges; bus read data registered, 1 edge after rd_en.
// Backpressure: none; rd_en/wr_en are accepted on every edge and bus_out holds until the next read.
module in_driver #(
    parameter int          DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] IN_ADDR         = 32'd12,
    parameter logic [31:0] EDGE_ADDR       = 32'd16,
    parameter logic [31:0] MASK_ADDR       = 32'd20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  IO_pins,
    input  logic [31:0] adress,
    input  logic [31:0] bus_in,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] bus_out,
    output logic        irq
);
    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef struct packed {
        logic [7:0] fall;
        logic [7:0] rise;
    } edge_t;

    logic [7:0]          sync_meta;
    logic [7:0]          sync_dat;
    logic [7:0]          stable;
    logic [7:0]          stable_nxt;
    logic [7:0][CW-1:0]  cnt;
    logic [7:0][CW-1:0]  cnt_nxt;
    edge_t               flags;
    edge_t               flags_nxt;
    edge_t               new_edges;
    logic [15:0]         mask;
    logic                edge_rd;
    logic [31:0]         rd_dat;
    logic                unused_bus_in;

    // Only the low half of the write bus reaches the mask register.
    assign unused_bus_in = ^bus_in[31:16];

    // A bit is accepted once it has disagreed with the stable value for DEBOUNCE_CYCLES
    // consecutive synchronized cycles; any agreement restarts the count.
    always_comb begin
        stable_nxt = stable;
        cnt_nxt    = '0;
        for (int i = 0; i < 8; i++) begin
            if (sync_dat[i] != stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sync_dat[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign new_edges.rise = stable_nxt & ~stable;
    assign new_edges.fall = stable & ~stable_nxt;

    // A clearing read drops exactly the bits it returned, so an edge landing on the
    // same edge survives and is seen by the next read.
    assign edge_rd   = rd_en && (adress == EDGE_ADDR);
    assign flags_nxt = edge_rd ? new_edges : edge_t'(flags | new_edges);

    always_comb begin
        rd_dat = '0;
        case (adress)
            IN_ADDR:   rd_dat = {24'b0, stable};
            EDGE_ADDR: rd_dat = {16'b0, flags};
            MASK_ADDR: rd_dat = {16'b0, mask};
            default:   rd_dat = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_meta <= '0;
            sync_dat  <= '0;
            stable    <= '0;
            cnt       <= '0;
            flags     <= '0;
            mask      <= '0;
            bus_out   <= '0;
        end else begin
            sync_meta <= IO_pins;
            sync_dat  <= sync_meta;
            stable    <= stable_nxt;
            cnt       <= cnt_nxt;
            flags     <= flags_nxt;
            if (wr_en && (adress == MASK_ADDR)) begin
                mask <= bus_in[15:0];
            end
            if (rd_en) begin
                bus_out <= rd_dat;
            end
        end
    end

    assign irq = |(flags & mask);

endmodule

// File: tb/tb_in_driver.sv
// Bench for in_driver: directed scenarios plus random traffic, all checked against a
// history-window reference model of the port.
module tb_in_driver;
    localparam int          DB     = 4;
    localparam logic [31:0] A_IN   = 32'd12;
    localparam logic [31:0] A_EDGE = 32'd16;
    localparam logic [31:0] A_MASK = 32'd20;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  IO_pins = 8'h00;
    logic [31:0] adress = 32'h0;
    logic [31:0] bus_in = 32'h0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] bus_out;
    logic        irq;

    in_driver #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk     (clk),
        .reset   (reset),
        .IO_pins (IO_pins),
        .adress  (adress),
        .bus_in  (bus_in),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .bus_out (bus_out),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: pins pass a 2-sample delay; a bit flips once the last DB
    // synchronized samples all disagree with its accepted value.
    logic [7:0]  m_d1, m_d2, m_stable, m_rise, m_fall;
    logic [15:0] m_mask;
    logic [31:0] m_bus;
    logic [7:0]  m_hist[$];

    task automatic mdl_reset();
        m_d1 = 0; m_d2 = 0; m_stable = 0; m_rise = 0; m_fall = 0;
        m_mask = 0; m_bus = 0;
        m_hist.delete();
    endtask

    function automatic logic [7:0] mdl_flips();
        logic [7:0] f;
        f = 8'hFF;
        if (m_hist.size() < DB) return 8'h00;
        for (int k = 0; k < DB; k++) f &= m_hist[m_hist.size() - 1 - k] ^ m_stable;
        return f;
    endfunction

    task automatic mdl_step();
        logic [7:0] nstab, nr, nf;
        m_hist.push_back(m_d2);
        if (m_hist.size() > DB) void'(m_hist.pop_front());
        m_d2 = m_d1;
        m_d1 = IO_pins;
        nstab = m_stable ^ mdl_flips();
        nr = nstab & ~m_stable;
        nf = m_stable & ~nstab;
        if (rd_en) begin
            if (adress == A_IN)        m_bus = {24'b0, m_stable};
            else if (adress == A_EDGE) m_bus = {16'b0, m_fall, m_rise};
            else if (adress == A_MASK) m_bus = {16'b0, m_mask};
            else                       m_bus = 32'h0;
        end
        if (rd_en && adress == A_EDGE) begin
            m_rise = nr; m_fall = nf;
        end else begin
            m_rise |= nr; m_fall |= nf;
        end
        if (wr_en && adress == A_MASK) m_mask = bus_in[15:0];
        m_stable = nstab;
    endtask

    function automatic logic m_irq();
        return |({m_fall, m_rise} & m_mask);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) mdl_step();
        @(negedge clk);
        chk("bus_out", bus_out, m_bus);
        chk("irq", {31'b0, irq}, {31'b0, m_irq()});
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic rd(input logic [31:0] a);
        adress = a; rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        adress = a; bus_in = d; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        mdl_reset();
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_bus", bus_out, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        reset = 1'b1;
        ticks(2);

        // Settle: 0x05 accepted on the 6th edge, visible to a read on the 7th.
        IO_pins = 8'h05;
        adress = A_IN; rd_en = 1'b1;
        ticks(6);
        chk("settle_early", bus_out, 32'h0);
        tick();
        chk("settle_in", bus_out, 32'h5);
        rd_en = 1'b0;

        // Read-to-clear.
        rd(A_EDGE);
        chk("edge_first", bus_out, 32'h5);
        rd(A_EDGE);
        chk("edge_second", bus_out, 32'h0);

        // Glitch of 3 cycles is rejected; a held level is accepted.
        IO_pins = 8'h85; ticks(3);
        IO_pins = 8'h05; ticks(8);
        rd(A_IN);   chk("glitch_in", bus_out, 32'h5);
        rd(A_EDGE); chk("glitch_edge", bus_out, 32'h0);
        chk("glitch_irq", {31'b0, irq}, 32'h0);
        IO_pins = 8'h85; ticks(8);
        rd(A_IN);   chk("held_in", bus_out, 32'h85);
        rd(A_EDGE); chk("held_edge", bus_out, 32'h80);

        // Mask fall[0] only.
        wr(A_MASK, 32'h0000_0100);
        IO_pins = 8'h84; ticks(7);
        chk("mask_irq_set", {31'b0, irq}, 32'h1);
        rd(A_EDGE);
        chk("mask_edge", bus_out, 32'h100);
        chk("mask_irq_clr", {31'b0, irq}, 32'h0);
        IO_pins = 8'h86; ticks(7);
        chk("mask_rise1_irq", {31'b0, irq}, 32'h0);
        rd(A_EDGE); chk("mask_rise1_edge", bus_out, 32'h2);

        // Clearing read on the same edge that rise[3] sets.
        IO_pins = 8'h87; ticks(7);
        IO_pins = 8'h8F; ticks(5);
        rd(A_EDGE); chk("simul_ret", bus_out, 32'h1);
        rd(A_EDGE); chk("simul_kept", bus_out, 32'h8);

        // Async reset mid-debounce with flags, mask and bus_out live.
        wr(A_MASK, 32'h0000_FFFF);
        IO_pins = 8'h8E; ticks(7);
        rd(A_IN);
        chk("pre_rst_bus", bus_out, 32'h8E);
        chk("pre_rst_irq", {31'b0, irq}, 32'h1);
        IO_pins = 8'h0E; ticks(4);
        #2 reset = 1'b0;
        #1;
        mdl_reset();
        chk("arst_bus", bus_out, 32'h0);
        chk("arst_irq", {31'b0, irq}, 32'h0);
        IO_pins = 8'hFF;
        @(negedge clk);
        reset = 1'b1;
        ticks(6);
        rd(A_IN);   chk("post_rst_in", bus_out, 32'hFF);
        rd(A_EDGE); chk("post_rst_edge", bus_out, 32'hFF);
        rd(A_MASK); chk("post_rst_mask", bus_out, 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 4) == 0) IO_pins = IO_pins ^ (8'h01 << $urandom_range(0, 7));
            rd_en = ($urandom_range(0, 9) < 3);
            wr_en = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 5))
                0, 1:    adress = A_EDGE;
                2:       adress = A_IN;
                3, 4:    adress = A_MASK;
                default: adress = 32'd24;
            endcase
            bus_in = $urandom;
            tick();
        end
        rd_en = 1'b0; wr_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/in_driver.md
Name: in_driver

Overview:
- Memory-mapped 8-bit input port; the read-side counterpart of the output-port driver on the same 32-bit address/data bus.
- Synchronizes and debounces external pins, and keeps sticky rising/falling edge flags with read-to-clear.
- Provides a maskable interrupt line and returns port/flag/mask data to the core on bus reads.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized cycles a changed level must persist before it is accepted (min 1).
- IN_ADDR, 32'd12, read: debounced port value in [7:0].
- EDGE_ADDR, 32'd16, read: edge flags, rising in [7:0], falling in [15:8]; read clears.
- MASK_ADDR, 32'd20, read/write: interrupt mask [15:0], bit-aligned with edge flags.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- IO_pins  input  8  external asynchronous input pins.
- adress  input  32  bus address.
- bus_in  input  32  write data.
- wr_en  input  1  write strobe.
- rd_en  input  1  read strobe.
- bus_out  output  32  registered read data.
- irq  output  1  interrupt, high while any unmasked edge flag is set.

Behaviour:
- Reset (reset=0, async): sync flops, stable, per-bit counters, flags, mask and bus_out go to 0. irq=0.
- Synchronizer: 2 flops per bit; sync value lags IO_pins by 2 clk edges.
- Debounce, per bit, on each edge:
  - If sync==stable: counter<=0.
  - Else if counter==DEBOUNCE_CYCLES-1: stable<=sync, counter<=0.
  - Else: counter<=counter+1.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - Pin-to-stable latency is 2+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized cycles is dropped, and its counter restarts from 0.
- Edge flags:
  - On the edge where stable[i] goes 0->1, rise[i]<=1; on the edge where it goes 1->0, fall[i]<=1.
  - Flags are sticky and visible in the same cycle as the new stable value.
- Reads: on an edge with rd_en=1, bus_out is loaded from the address decode:
  - IN_ADDR: {24'b0, stable}.
  - EDGE_ADDR: {16'b0, fall, rise}.
  - MASK_ADDR: {16'b0, mask}.
  - Any other address: 0.
  - bus_out holds its value until the next read. Latency is 1 edge.
- Read-to-clear:
  - A read of EDGE_ADDR clears exactly the flag bits it returned: flags <= (flags & ~returned) | new_edges.
  - An edge detected in the same cycle as the clearing read is kept set, and that read returns the pre-edge value.
- Writes: on an edge with wr_en=1 and adress==MASK_ADDR, mask<=bus_in[15:0]. Writes to any other address are ignored; IN_ADDR and EDGE_ADDR are read-only.
- rd_en and wr_en in the same cycle: both actions take effect. A read of MASK_ADDR returns the old mask.
- irq = |({fall,rise} & mask), combinational from registers; no glitch sources beyond those registers.
- Reset mid-debounce: all progress is lost. After reset is released, a pin held high is accepted after 2+DEBOUNCE_CYCLES edges and then sets its rise flag (intended power-up behaviour).

Test Plan:
- Settle: DEBOUNCE_CYCLES=4, reset released, IO_pins=8'h00 -> 8'h05 at edge 0 -> stable=8'h05 after edge 6, not before. Read IN_ADDR -> bus_out=32'h00000005 one edge later.
- Glitch rejection: bit7 high for 3 cycles then low -> stable unchanged at 8'h05, rise[7]=0, irq=0. Bit7 high for 4+ cycles -> stable=8'h85, rise[7]=1.
- Read-to-clear: after the 8'h05 transition, read EDGE_ADDR -> 32'h00000005. Immediate second read -> 32'h00000000.
- Interrupt mask: write MASK_ADDR=32'h00000100, drive bit0 1->0 -> after debounce fall[0]=1 and irq=1. Read EDGE_ADDR -> 32'h00000100, and irq=0 the next cycle. A rise on bit1 alone leaves irq=0.
- Simultaneous clear and edge: time an EDGE_ADDR read on the edge where rise[3] sets, with rise[0] already set -> bus_out=32'h00000001, then rise[3] remains 1 and rise[0]=0.
- Async reset mid-operation: assert reset between edges with a bit 2 cycles into debounce and flags set -> bus_out, flags, mask and irq go to 0 immediately, without waiting for clk. After release with pins=8'hFF -> stable=8'hFF and rise=8'hFF after 6 edges.
